// File: rtl/divider_32b_seq_pkg.sv
// Shared types and constants for the iterative 32-bit divider.
// Restoring radix-2, one quotient bit per clock.
package divider_32b_seq_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int          STEPS        = 32;
    localparam logic [4:0]  STEP_LAST    = 5'(STEPS - 1);
    localparam logic [31:0] DIVZERO_QUOT = 32'hFFFF_FFFF;

endpackage

// File: rtl/divider_32b_seq_step.sv
// One restoring radix-2 step: shift remainder/dividend, conditionally subtract.
// Purely combinational so it can be replicated for an unrolled variant.
module div_step_32b (
    input  logic [32:0] r,
    input  logic [31:0] dvd,
    input  logic [31:0] divisor,
    output logic [32:0] r_next,
    output logic [31:0] dvd_next,
    output logic        qbit
);

    logic [32:0] r_sh;
    logic [32:0] r_sub;

    assign r_sh  = {r[31:0], dvd[31]};
    assign r_sub = r_sh - {1'b0, divisor};

    // A set top bit already means the shifted value exceeds any divisor.
    assign qbit     = r[32] | (r_sh >= {1'b0, divisor});
    assign r_next   = qbit ? r_sub : r_sh;
    assign dvd_next = {dvd[30:0], 1'b0};

endmodule

// File: rtl/divider_32b_seq.sv
// Iterative unsigned 32/32 divider: 32-cycle latency, done pulse,
// divide-by-zero flagged in a single cycle.
module divider_32b_seq
    import divider_32b_seq_pkg::*;
(
    input  logic        iClk,
    input  logic        iRstN,
    input  logic        iEn,
    input  logic        iClr,
    input  logic [31:0] iData0,
    input  logic [31:0] iData1,
    output logic [31:0] oQuot,
    output logic [31:0] oRem,
    output logic        oBusy,
    output logic        oDone,
    output logic        oDivZero
);

    state_t      state;
    state_t      state_nx;
    logic [4:0]  cnt;
    logic [32:0] r;
    logic [31:0] dvd;
    logic [31:0] dsr;
    logic        start;
    logic        last;

    logic [32:0] r_next;
    logic [31:0] dvd_next;
    logic        qbit;
    logic [31:0] quot_next;

    div_step_32b u_step (
        .r        (r),
        .dvd      (dvd),
        .divisor  (dsr),
        .r_next   (r_next),
        .dvd_next (dvd_next),
        .qbit     (qbit)
    );

    // Quotient bits enter the vacated low end of the dividend register.
    assign quot_next = dvd_next | {31'd0, qbit};

    always_comb begin
        state_nx = state;
        start    = 1'b0;
        last     = 1'b0;
        if (iClr) begin
            state_nx = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (iEn) begin
                        start = 1'b1;
                        if (iData1 != 32'd0)
                            state_nx = RUN;
                    end
                end
                RUN: begin
                    if (cnt == STEP_LAST) begin
                        last     = 1'b1;
                        state_nx = IDLE;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            cnt      <= '0;
            r        <= '0;
            dvd      <= '0;
            dsr      <= '0;
            oQuot    <= '0;
            oRem     <= '0;
            oDone    <= 1'b0;
            oDivZero <= 1'b0;
        end else begin
            oDone <= 1'b0;
            if (iClr) begin
                cnt      <= '0;
                r        <= '0;
                dvd      <= '0;
                dsr      <= '0;
                oQuot    <= '0;
                oRem     <= '0;
                oDivZero <= 1'b0;
            end else if (start) begin
                cnt <= '0;
                r   <= '0;
                dvd <= iData0;
                dsr <= iData1;
                if (iData1 == 32'd0) begin
                    oQuot    <= DIVZERO_QUOT;
                    oRem     <= iData0;
                    oDivZero <= 1'b1;
                    oDone    <= 1'b1;
                end
            end else if (state == RUN) begin
                r   <= r_next;
                dvd <= quot_next;
                cnt <= cnt + 5'd1;
                if (last) begin
                    oQuot    <= quot_next;
                    oRem     <= r_next[31:0];
                    oDivZero <= 1'b0;
                    oDone    <= 1'b1;
                end
            end
        end
    end

    assign oBusy = (state == RUN);

endmodule

// File: doc/divider_32b_seq.md
# divider_32b_seq

Iterative unsigned 32-bit integer divider, the inverse companion of the single-cycle 32-bit multiplier in the arithmetic module library. It accepts a dividend/divisor pair on a start pulse and produces a 32-bit quotient and a 32-bit remainder using one restoring radix-2 step per cycle. Completion is signalled by a one-cycle `oDone` pulse. Datapaths use it where a full-width combinational divide would not meet timing.

## Interface
- No parameters; width fixed at 32.

- `iClk` in 1: clock, all state updates on rising edge.
- `iRstN` in 1: asynchronous reset, active-low.
- `iEn` in 1: start request; sampled only in IDLE.
- `iClr` in 1: synchronous clear; highest priority after reset.
- `iData0` in 32: dividend, unsigned; captured on accepted start.
- `iData1` in 32: divisor, unsigned; captured on accepted start.
- `oQuot` out 32: quotient; holds the last result.
- `oRem` out 32: remainder; holds the last result.
- `oBusy` out 1: high while an operation is in flight.
- `oDone` out 1: one-cycle pulse; results valid from this cycle.
- `oDivZero` out 1: last completed operation had divisor 0.

## Operation
- States:
  - IDLE: waits for a start.
  - RUN: 32 iterations.
- Start is accepted in IDLE when `iEn`=1 and `iClr`=0; operands are latched into internal registers.
  - `iData1` != 0: go to RUN with step counter = 0 and partial remainder = 0.
  - `iData1` == 0: no RUN. Same edge writes `oQuot`=0xFFFFFFFF, `oRem`=dividend, `oDivZero`=1 and `oDone`=1.
- Each RUN step, in order:
  1. r = {r[31:0], dvd[31]}, 33-bit.
  2. Shift dvd left by one.
  3. If r >= divisor, then r -= divisor and shift in quotient bit 1; otherwise shift in 0.
- The partial remainder register is 33 bits to hold the shifted value before subtraction. The quotient shares the dvd shift register.
- After step 31:
  - Write `oQuot` and `oRem` (low 32 bits of r).
  - Set `oDivZero`=0 and `oDone`=1.
  - Return to IDLE.
- `iEn` during RUN is ignored; there is no queueing.
- `oDone` is high for exactly one cycle per completed operation. It is 0 in all other cycles.
- `iClr`=1 in any state:
  - Next state is IDLE.
  - Counter and internal registers go to 0.
  - `oQuot`, `oRem`, `oDivZero` and `oDone` go to 0.
  - A same-cycle `iEn` is ignored.
- `iRstN` low, including mid-operation: all registers and outputs go to 0 immediately and the state is IDLE. Operation resumes only on a new start after reset release.
- Input operands may change freely after the start edge without affecting the result.

## Timing
- Reset values are all 0: `oQuot`, `oRem`, `oBusy`, `oDone`, `oDivZero`, state=IDLE, counter=0.
- Normal start accepted at edge k:
  - `oBusy`=1 after edge k.
  - RUN steps occur at edges k+1..k+32.
  - Results and `oDone`=1 are visible after edge k+32; `oBusy`=0 in the same cycle.
  - Latency is 32 cycles from start edge to `oDone`.
- Divide-by-zero start at edge k: `oDone`=1 after edge k; `oBusy` never asserts. Latency is 1 cycle.
- Back-to-back: `iEn`=1 in the `oDone` cycle is accepted at edge k+33. Sustained throughput is one result per 33 cycles.
- `oBusy` is a registered state decode (state == RUN); no combinational input-to-output paths.

## Structure
- A shared package/header carries:
  - State encodings (IDLE, RUN).
  - The step-count constant (32).
  - The divide-by-zero quotient constant (0xFFFFFFFF).
- One sub-module is natural: `div_step_32b`, a combinational conditional subtract/shift that takes r, dvd and divisor and returns next r, next dvd and the quotient bit. It is reusable for a future unrolled or pipelined variant.
- The top level holds the FSM, the 5-bit step counter, the operand registers and the output registers.

## Test plan
- 100 / 7, start at edge k: `oDone` after edge k+32 with `oQuot`=14, `oRem`=2, `oDivZero`=0; `oBusy` high for exactly 32 cycles.
- 0xFFFFFFFF / 1 → `oQuot`=0xFFFFFFFF, `oRem`=0. Also 5 / 9 → `oQuot`=0, `oRem`=5. Also 0x80000000 / 0xFFFFFFFF → `oQuot`=0, `oRem`=0x80000000.
- 1234 / 0: `oDone` one cycle after start with `oQuot`=0xFFFFFFFF, `oRem`=1234, `oDivZero`=1; the next normal divide clears `oDivZero`.
- Start 1000/3, then pulse `iEn` with 50/5 at step 10 → ignored; result is `oQuot`=333, `oRem`=1. Next, start 1000/3, change `iData0` and `iData1` after the start edge → result unchanged.
- Abort and reset mid-operation:
  - `iClr` at step 15 → all outputs 0, no `oDone`, IDLE.
  - `iRstN` low at step 20 → asynchronous zero.
  - A following 81/9 yields 9 r 0.
- Back-to-back: `iEn` held high with 200/10 then 17/4 → two `oDone` pulses 33 cycles apart with (20,0) then (4,1).
